// File: rtl/fleet_controller.sv
// Enemy row sequencer: fleet position, march direction, alive mask and game phase,
// with one bullet/ship overlap comparator time-multiplexed across the row each frame.
module fleet_controller #(
  parameter int NUM_ENEMIES_P     = 8,
  parameter int ENEMY_W_P         = 20,
  parameter int ENEMY_H_P         = 14,
  parameter int SPACING_P         = 40,
  parameter int LEFT_START_P      = 40,
  parameter int TOP_START_P       = 60,
  parameter int STEP_PX_P         = 4,
  parameter int DROP_PX_P         = 10,
  parameter int FRAMES_PER_STEP_P = 30,
  parameter int LEFT_LIMIT_P      = 10,
  parameter int RIGHT_LIMIT_P     = 600,
  parameter int LAND_ROW_P        = 389
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             frame_i,
  input  logic                             start_i,
  input  logic                             bullet_active_i,
  input  logic [9:0]                       bullet_left_i,
  input  logic [9:0]                       bullet_right_i,
  input  logic [9:0]                       bullet_top_i,
  input  logic [9:0]                       bullet_bot_i,
  output logic [9:0]                       fleet_left_o,
  output logic [9:0]                       fleet_top_o,
  output logic [NUM_ENEMIES_P-1:0]         alive_mask_o,
  output logic                             hit_o,
  output logic [$clog2(NUM_ENEMIES_P)-1:0] hit_id_o,
  output logic [1:0]                       state_o,
  output logic                             landed_o,
  output logic                             cleared_o
);

  localparam int IDX_W = $clog2(NUM_ENEMIES_P);
  localparam int CNT_W = (FRAMES_PER_STEP_P > 1) ? $clog2(FRAMES_PER_STEP_P) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CLEARED = 2'd2,
    ST_LANDED  = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic [9:0]               fleet_left_reg, fleet_top_reg;
  logic [NUM_ENEMIES_P-1:0] alive_mask_reg;
  logic                     dir_right_reg;
  logic [CNT_W-1:0]         step_cnt_reg;
  logic                     start_prev_reg;
  logic                     scan_busy_reg;
  logic [IDX_W-1:0]         scan_idx_reg;
  logic                     commit_reg;
  logic                     hit_reg;
  logic [IDX_W-1:0]         hit_id_reg;

  logic [10:0]      ship_offset [NUM_ENEMIES_P];
  logic [10:0]      scan_left, scan_right, row_top, row_bot, right_ext, left_ext;
  logic [IDX_W-1:0] first_idx, last_idx;
  logic [9:0]       left_after, top_after;
  logic             start_edge, restart, overlap, hit_now, scan_last;
  logic             step_due, need_drop, landing, mask_empty;

  // Column offsets are constants, so the ship-index multiply becomes a table lookup.
  for (genvar gi = 0; gi < NUM_ENEMIES_P; gi++) begin : g_offset
    assign ship_offset[gi] = 11'(gi * SPACING_P);
  end

  assign start_edge = start_i & ~start_prev_reg;
  assign restart    = start_edge && (state_reg == ST_CLEARED || state_reg == ST_LANDED);

  assign scan_left  = {1'b0, fleet_left_reg} + ship_offset[scan_idx_reg];
  assign scan_right = scan_left + 11'(ENEMY_W_P);
  assign row_top    = {1'b0, fleet_top_reg};
  assign row_bot    = row_top + 11'(ENEMY_H_P);
  assign overlap    = ({1'b0, bullet_left_i}  < scan_right) && ({1'b0, bullet_right_i} > scan_left) &&
                      ({1'b0, bullet_top_i}   < row_bot)    && ({1'b0, bullet_bot_i}   > row_top);
  assign hit_now    = scan_busy_reg && bullet_active_i && alive_mask_reg[scan_idx_reg] && overlap;
  assign scan_last  = (scan_idx_reg == IDX_W'(NUM_ENEMIES_P - 1));

  always_comb begin
    first_idx = '0;
    last_idx  = '0;
    for (int i = NUM_ENEMIES_P - 1; i >= 0; i--)
      if (alive_mask_reg[i]) first_idx = IDX_W'(i);
    for (int i = 0; i < NUM_ENEMIES_P; i++)
      if (alive_mask_reg[i]) last_idx = IDX_W'(i);
  end

  // Extents come from surviving ships only, so a thinned row marches further.
  assign step_due   = (step_cnt_reg == CNT_W'(FRAMES_PER_STEP_P - 1));
  assign right_ext  = {1'b0, fleet_left_reg} + ship_offset[last_idx] + 11'(ENEMY_W_P) + 11'(STEP_PX_P);
  assign left_ext   = {1'b0, fleet_left_reg} + ship_offset[first_idx];
  assign need_drop  = dir_right_reg ? (right_ext > 11'(RIGHT_LIMIT_P))
                                    : (left_ext < 11'(LEFT_LIMIT_P + STEP_PX_P));
  assign mask_empty = (alive_mask_reg == '0);

  always_comb begin
    left_after = fleet_left_reg;
    top_after  = fleet_top_reg;
    if (step_due) begin
      if (need_drop)          top_after  = fleet_top_reg + 10'(DROP_PX_P);
      else if (dir_right_reg) left_after = fleet_left_reg + 10'(STEP_PX_P);
      else                    left_after = fleet_left_reg - 10'(STEP_PX_P);
    end
  end

  assign landing = ({1'b0, top_after} + 11'(ENEMY_H_P)) >= 11'(LAND_ROW_P);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_edge) state_next = ST_RUN;
      ST_RUN: begin
        if (commit_reg) begin
          if (mask_empty)   state_next = ST_CLEARED;
          else if (landing) state_next = ST_LANDED;
        end
      end
      default: if (start_edge) state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fleet_left_reg <= 10'(LEFT_START_P);
      fleet_top_reg  <= 10'(TOP_START_P);
      alive_mask_reg <= '1;
      dir_right_reg  <= 1'b1;
      step_cnt_reg   <= '0;
      start_prev_reg <= 1'b0;
      scan_busy_reg  <= 1'b0;
      scan_idx_reg   <= '0;
      commit_reg     <= 1'b0;
      hit_reg        <= 1'b0;
      hit_id_reg     <= '0;
    end else begin
      start_prev_reg <= start_i;
      hit_reg        <= 1'b0;
      if (restart) begin
        fleet_left_reg <= 10'(LEFT_START_P);
        fleet_top_reg  <= 10'(TOP_START_P);
        alive_mask_reg <= '1;
        dir_right_reg  <= 1'b1;
        step_cnt_reg   <= '0;
        scan_busy_reg  <= 1'b0;
        commit_reg     <= 1'b0;
      end else if (state_reg == ST_RUN) begin
        if (scan_busy_reg) begin
          if (hit_now) begin
            alive_mask_reg[scan_idx_reg] <= 1'b0;
            hit_reg       <= 1'b1;
            hit_id_reg    <= scan_idx_reg;
            scan_busy_reg <= 1'b0;
            commit_reg    <= 1'b1;
          end else if (scan_last) begin
            scan_busy_reg <= 1'b0;
            commit_reg    <= 1'b1;
          end else begin
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
          end
        end else if (commit_reg) begin
          commit_reg <= 1'b0;
          // A cleared row stays where it is; only a live row marches.
          if (!mask_empty) begin
            step_cnt_reg   <= step_due ? '0 : step_cnt_reg + CNT_W'(1);
            fleet_left_reg <= left_after;
            fleet_top_reg  <= top_after;
            if (step_due && need_drop) dir_right_reg <= ~dir_right_reg;
          end
        end else if (frame_i) begin
          scan_busy_reg <= 1'b1;
          scan_idx_reg  <= '0;
        end
      end
    end
  end

  assign fleet_left_o = fleet_left_reg;
  assign fleet_top_o  = fleet_top_reg;
  assign alive_mask_o = alive_mask_reg;
  assign hit_o        = hit_reg;
  assign hit_id_o     = hit_id_reg;
  assign state_o      = state_reg;
  assign landed_o     = (state_reg == ST_LANDED);
  assign cleared_o    = (state_reg == ST_CLEARED);

endmodule
